rx_timer: RTL

RX_TIMER -- requirements
Module: rx_timer

---
 rtl/rx_timer_pkg.sv | 21 ++
 rtl/flex_counter.sv | 43 ++++
 rtl/rx_timer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rx_timer_pkg.sv
// Shared types and default constants for the serial receive bit timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rx_timer_pkg;

  // Timer sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default timing: 10 clocks per bit, sample mid-bit, 8 data bits + stop
  localparam int DEF_CLKS_PER_BIT    = 10;
  localparam int DEF_SAMPLE_POS      = 5;
  localparam int DEF_BITS_PER_PACKET = 9;

  // Bit index width covers up to 15 bit periods per packet
  localparam int BIT_IDX_W = 4;

endpackage

// File: rtl/flex_counter.sv
// Generic counter: counts 1..rollover_val then wraps to 1; clear forces 0.
// Latency: count_out reflects clear/count_enable one clock after they are sampled.
// Backpressure: none; holds its value whenever count_enable is low.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  // Next count: clear wins, otherwise step and wrap back to 1 at rollover
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = NUM_CNT_BITS'(1);
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  // Count register with asynchronous clear on reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/rx_timer.sv
// Times one serial packet: strobes once per bit at SAMPLE_POS, pulses packet_done at the end.
// Latency: first strobe SAMPLE_POS-1 clocks after the start edge; done BITS_PER_PACKET*CLKS_PER_BIT after it.
// Backpressure: none; dropping enable_timing mid-packet aborts to IDLE without packet_done.
module rx_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_POS      = DEF_SAMPLE_POS,
  parameter int BITS_PER_PACKET = DEF_BITS_PER_PACKET
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable_timing,
  output logic                 shift_strobe,
  output logic                 packet_done,
  output logic                 busy,
  output logic [BIT_IDX_W-1:0] bit_idx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0]     CLK_ROLL = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     SAMPLE_V = CNT_W'(SAMPLE_POS);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BITS_PER_PACKET - 1);
  // Bit counter never reaches this; the FSM clears it after the last bit
  localparam logic [BIT_IDX_W-1:0] BIT_ROLL = '1;

  // Reject parameter sets outside the supported timing range
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_clks_per_bit
    $error("rx_timer: CLKS_PER_BIT=%0d outside 2..255", CLKS_PER_BIT);
  end
  if (SAMPLE_POS < 1 || SAMPLE_POS > CLKS_PER_BIT) begin : g_bad_sample_pos
    $error("rx_timer: SAMPLE_POS=%0d outside 1..CLKS_PER_BIT", SAMPLE_POS);
  end
  if (BITS_PER_PACKET < 1 || BITS_PER_PACKET > 15) begin : g_bad_bits_per_packet
    $error("rx_timer: BITS_PER_PACKET=%0d outside 1..15", BITS_PER_PACKET);
  end

  state_e               state_q;
  state_e               state_d;
  logic [CNT_W-1:0]     clk_cnt;
  logic                 clk_clr;
  logic                 clk_en;
  logic                 bit_clr;
  logic                 bit_en;
  logic                 bit_end;
  logic                 last_bit;

  assign bit_end  = (clk_cnt == CLK_ROLL);
  assign last_bit = (bit_idx == LAST_BIT);

  // Next state and counter controls; counters sit at 0 whenever not counting
  always_comb begin
    state_d = state_q;
    clk_clr = 1'b0;
    clk_en  = 1'b0;
    bit_clr = 1'b0;
    bit_en  = 1'b0;
    case (state_q)
      IDLE: begin
        bit_clr = 1'b1;
        if (enable_timing) begin
          // Clock counter is 0 in IDLE, so one enabled step loads 1
          state_d = COUNT;
          clk_en  = 1'b1;
        end else begin
          clk_clr = 1'b1;
        end
      end
      COUNT: begin
        if (!enable_timing) begin
          state_d = IDLE;
          clk_clr = 1'b1;
          bit_clr = 1'b1;
        end else if (bit_end && last_bit) begin
          state_d = DONE;
          clk_clr = 1'b1;
          bit_clr = 1'b1;
        end else begin
          clk_en = 1'b1;
          bit_en = bit_end;
        end
      end
      DONE: begin
        state_d = IDLE;
        clk_clr = 1'b1;
        bit_clr = 1'b1;
      end
      default: begin
        state_d = IDLE;
        clk_clr = 1'b1;
        bit_clr = 1'b1;
      end
    endcase
  end

  // State register, forced to IDLE by reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_clk_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clk_clr),
    .count_enable (clk_en),
    .rollover_val (CLK_ROLL),
    .count_out    (clk_cnt)
  );

  flex_counter #(
    .NUM_CNT_BITS (BIT_IDX_W)
  ) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (bit_clr),
    .count_enable (bit_en),
    .rollover_val (BIT_ROLL),
    .count_out    (bit_idx)
  );

  // Outputs decode registered state only, so they are glitch-free and reset to 0
  assign busy         = (state_q == COUNT);
  assign shift_strobe = (state_q == COUNT) && (clk_cnt == SAMPLE_V);
  assign packet_done  = (state_q == DONE);

endmodule
